// File: rtl/skinny_batch_sequencer.sv
// skinny_batch_sequencer: runs a batch of back-to-back SKINNY-128-384
// encryptions for trace acquisition. The plaintext is either held fixed or
// chained from the previous ciphertext. A watchdog aborts a hung encryption.
// Every output comes straight from a register.
module skinny_batch_sequencer #(
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_mode,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [127:0]     pt_i,
  output logic             core_start_o,
  output logic [127:0]     core_pt_o,
  input  logic             core_done_i,
  input  logic [127:0]     core_ct_i,
  output logic [127:0]     ct_o,
  output logic [CNT_W-1:0] iter_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             trigger_o
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Watchdog expires on the cycle it holds TIMEOUT-1, so the exit lands
  // exactly TIMEOUT cycles after start went high.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic             mode_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [127:0]     pt_q;
  logic [WD_W-1:0]  wd;

  logic [CNT_W-1:0] iter_inc;
  logic [GAP_W-1:0] gap_load;

  // Next completed-iteration count and the gap length (never zero, so the
  // core always sees start low for at least one cycle to re-arm).
  assign iter_inc = iter_o + CNT_W'(1);
  assign gap_load = (gap_q == '0) ? GAP_W'(1) : gap_q;

  // The plaintext register feeds the core directly, and the trigger is the
  // registered start itself.
  assign core_pt_o = pt_q;
  assign trigger_o = core_start_o;

  // Batch FSM with all control and data registers and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      count_q      <= '0;
      mode_q       <= 1'b0;
      gap_q        <= '0;
      gap_cnt      <= '0;
      pt_q         <= '0;
      wd           <= '0;
      ct_o         <= '0;
      iter_o       <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
      core_start_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_count != '0) begin
              count_q      <= cfg_count;
              mode_q       <= cfg_mode;
              gap_q        <= cfg_gap;
              pt_q         <= pt_i;
              iter_o       <= '0;
              timeout_o    <= 1'b0;
              wd           <= '0;
              state        <= RUN;
              busy_o       <= 1'b1;
              core_start_o <= 1'b1;
            end else begin
              // An empty batch completes immediately and leaves state alone.
              done_o <= 1'b1;
            end
          end
        end

        RUN: begin
          if (cfg_abort) begin
            // Abort wins over a same-cycle done: nothing is captured.
            state        <= IDLE;
            busy_o       <= 1'b0;
            core_start_o <= 1'b0;
          end else if (core_done_i) begin
            ct_o         <= core_ct_i;
            iter_o       <= iter_inc;
            core_start_o <= 1'b0;
            if (mode_q) begin
              pt_q <= core_ct_i;
            end
            if (iter_inc == count_q) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= gap_load;
            end
          end else if (wd == WD_LAST) begin
            timeout_o    <= 1'b1;
            done_o       <= 1'b1;
            state        <= IDLE;
            busy_o       <= 1'b0;
            core_start_o <= 1'b0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end

        GAP: begin
          if (cfg_abort) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state        <= RUN;
            core_start_o <= 1'b1;
            wd           <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state        <= IDLE;
          busy_o       <= 1'b0;
          core_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_batch_sequencer.sv
// Directed testbench for skinny_batch_sequencer with a small behavioural core
// (done five cycles after start, ct = pt XOR all-ones) and a pulse monitor.
module tb_skinny_batch_sequencer;

  localparam int CNT_W   = 16;
  localparam int GAP_W   = 8;
  localparam int TIMEOUT = 16;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic             clk;
  logic             n_reset;
  logic             cfg_start;
  logic             cfg_abort;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_mode;
  logic [GAP_W-1:0] cfg_gap;
  logic [127:0]     pt_i;
  logic             core_start_o;
  logic [127:0]     core_pt_o;
  logic             core_done_i;
  logic [127:0]     core_ct_i;
  logic [127:0]     ct_o;
  logic [CNT_W-1:0] iter_o;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic             trigger_o;

  skinny_batch_sequencer #(
    .CNT_W   (CNT_W),
    .GAP_W   (GAP_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_count    (cfg_count),
    .cfg_mode     (cfg_mode),
    .cfg_gap      (cfg_gap),
    .pt_i         (pt_i),
    .core_start_o (core_start_o),
    .core_pt_o    (core_pt_o),
    .core_done_i  (core_done_i),
    .core_ct_i    (core_ct_i),
    .ct_o         (ct_o),
    .iter_o       (iter_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .trigger_o    (trigger_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: auto mode answers five cycles after start; manual mode lets
  // the stimulus drive done/ct directly.
  logic         auto_en = 1'b0;
  logic         man_done = 1'b0;
  logic [127:0] man_ct = '0;
  logic         model_done = 1'b0;
  logic [127:0] model_ct = '0;
  int           cyc = 0;

  assign core_done_i = auto_en ? model_done : man_done;
  assign core_ct_i   = auto_en ? model_ct   : man_ct;

  always @(negedge clk) begin
    if (core_start_o) begin
      cyc        <= cyc + 1;
      model_done <= auto_en && (cyc == 4);
    end else begin
      cyc        <= 0;
      model_done <= 1'b0;
    end
    model_ct <= core_pt_o ^ ONES;
  end

  // Monitor: start pulses, done pulses, start-low gaps inside a batch, the
  // plaintext seen at each start, and any plaintext change mid-RUN.
  int           starts = 0;
  int           dones = 0;
  int           pt_glitch = 0;
  int           low_len = 0;
  logic         armed = 1'b0;
  logic         prev_start = 1'b0;
  logic [127:0] last_pt = '0;
  int           gaps[$];
  logic [127:0] pt_log[$];

  always @(negedge clk) begin
    if (done_o) dones <= dones + 1;
    if (core_start_o && !prev_start) begin
      starts <= starts + 1;
      pt_log.push_back(core_pt_o);
    end
    if (core_start_o && prev_start && (core_pt_o != last_pt)) pt_glitch <= pt_glitch + 1;
    last_pt    <= core_pt_o;
    prev_start <= core_start_o;
    if (!busy_o) begin
      low_len <= 0;
      armed   <= 1'b0;
    end else if (core_start_o) begin
      if (armed && !prev_start) gaps.push_back(low_len);
      armed   <= 1'b1;
      low_len <= 0;
    end else begin
      low_len <= low_len + 1;
    end
  end

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse cfg_start for one cycle; returns at the negedge after the launch edge.
  task automatic launch(input logic [CNT_W-1:0] cnt, input logic mode,
                        input logic [GAP_W-1:0] gap, input logic [127:0] pt);
    cfg_count = cnt;
    cfg_mode  = mode;
    cfg_gap   = gap;
    pt_i      = pt;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Waits (bounded) for done_o; k = negedges waited, 0 if it never came.
  task automatic wait_done(input int limit, output int k);
    k = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done_o) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    int s0, d0, g0, p0;
    logic found;
    logic pt_ok;

    n_reset   = 1'b0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_count = '0;
    cfg_mode  = 1'b0;
    cfg_gap   = '0;
    pt_i      = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy",    128'(busy_o), 128'd0);
    chk("rst_start",   128'(core_start_o), 128'd0);
    chk("rst_trigger", 128'(trigger_o), 128'd0);
    chk("rst_done",    128'(done_o), 128'd0);
    chk("rst_timeout", 128'(timeout_o), 128'd0);
    chk("rst_iter",    128'(iter_o), 128'd0);
    chk("rst_ct",      ct_o, 128'd0);
    chk("rst_pt",      core_pt_o, 128'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // Fixed mode: 3 encryptions, gap 4
    auto_en = 1'b1;
    s0 = starts; d0 = dones; g0 = gaps.size(); p0 = pt_log.size();
    launch(16'd3, 1'b0, 8'd4, 128'd1);
    chk("fix_busy_launch",  128'(busy_o), 128'd1);
    chk("fix_start_launch", 128'(core_start_o), 128'd1);
    chk("fix_trig_launch",  128'(trigger_o), 128'd1);
    chk("fix_pt_launch",    core_pt_o, 128'd1);
    wait_done(100, k);
    chk("fix_latency", 128'(k), 128'd23);
    chk("fix_iter",    128'(iter_o), 128'd3);
    chk("fix_ct",      ct_o, ONES ^ 128'd1);
    chk("fix_busy_end", 128'(busy_o), 128'd0);
    chk("fix_start_end", 128'(core_start_o), 128'd0);
    @(negedge clk);
    chk("fix_done_one_cycle", 128'(done_o), 128'd0);
    @(negedge clk);
    chk("fix_starts", 128'(starts - s0), 128'd3);
    chk("fix_dones",  128'(dones - d0), 128'd1);
    chk("fix_ngaps",  128'(gaps.size() - g0), 128'd2);
    chk("fix_gap0",   128'(gaps[g0]), 128'd4);
    chk("fix_gap1",   128'(gaps[g0+1]), 128'd4);
    pt_ok = (pt_log[p0] == 128'd1) && (pt_log[p0+1] == 128'd1) && (pt_log[p0+2] == 128'd1);
    chk("fix_pt_all", 128'(pt_ok), 128'd1);
    chk("fix_pt_stable", 128'(pt_glitch), 128'd0);

    // Chained mode: 2 encryptions, gap 0 behaves as 1
    g0 = gaps.size(); p0 = pt_log.size();
    launch(16'd2, 1'b1, 8'd0, 128'd1);
    wait_done(100, k);
    chk("chn_latency", 128'(k), 128'd11);
    chk("chn_pt2",     pt_log[p0+1], ONES ^ 128'd1);
    chk("chn_ct",      ct_o, 128'd1);
    chk("chn_iter",    128'(iter_o), 128'd2);
    chk("chn_gap_min", 128'(gaps[g0]), 128'd1);

    // Watchdog: core never answers
    auto_en = 1'b0;
    launch(16'd1, 1'b0, 8'd0, 128'd5);
    wait_done(100, k);
    chk("wd_latency", 128'(k), 128'd16);
    chk("wd_timeout", 128'(timeout_o), 128'd1);
    chk("wd_iter",    128'(iter_o), 128'd0);
    chk("wd_ct_hold", ct_o, 128'd1);
    chk("wd_busy",    128'(busy_o), 128'd0);
    @(negedge clk);
    chk("wd_sticky",  128'(timeout_o), 128'd1);
    auto_en = 1'b1;
    launch(16'd1, 1'b0, 8'd0, 128'd7);
    chk("wd_cleared", 128'(timeout_o), 128'd0);
    wait_done(100, k);
    chk("wd_rerun_latency", 128'(k), 128'd5);
    chk("wd_rerun_iter",    128'(iter_o), 128'd1);
    chk("wd_rerun_ct",      ct_o, ONES ^ 128'd7);

    // Abort during the gap after iteration 1 of 4
    launch(16'd4, 1'b0, 8'd4, 128'd2);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy_o && !core_start_o && (iter_o == 16'd1)) begin
        found = 1'b1;
        break;
      end
    end
    chk("abt_reached_gap", 128'(found), 128'd1);
    d0 = dones;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    chk("abt_busy",  128'(busy_o), 128'd0);
    chk("abt_start", 128'(core_start_o), 128'd0);
    chk("abt_iter",  128'(iter_o), 128'd1);
    repeat (3) @(negedge clk);
    chk("abt_no_done", 128'(dones - d0), 128'd0);
    chk("abt_ct",      ct_o, ONES ^ 128'd2);

    // Abort and done in the same cycle: ciphertext not captured
    auto_en = 1'b0;
    launch(16'd2, 1'b0, 8'd0, 128'd3);
    man_done  = 1'b1;
    man_ct    = 128'hDEAD_BEEF;
    cfg_abort = 1'b1;
    @(negedge clk);
    man_done  = 1'b0;
    cfg_abort = 1'b0;
    chk("abd_ct",   ct_o, ONES ^ 128'd2);
    chk("abd_iter", 128'(iter_o), 128'd0);
    chk("abd_busy", 128'(busy_o), 128'd0);
    chk("abd_done", 128'(done_o), 128'd0);

    // Zero count: done pulse only
    cfg_count = '0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("zero_done",  128'(done_o), 128'd1);
    chk("zero_busy",  128'(busy_o), 128'd0);
    chk("zero_start", 128'(core_start_o), 128'd0);
    @(negedge clk);
    chk("zero_done_clear", 128'(done_o), 128'd0);

    // Start while busy is ignored
    auto_en = 1'b1;
    launch(16'd2, 1'b0, 8'd1, 128'd4);
    repeat (3) @(negedge clk);
    cfg_count = 16'd5;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done(100, k);
    chk("bsy_latency", 128'(k), 128'd7);
    chk("bsy_iter",    128'(iter_o), 128'd2);

    // Asynchronous reset mid-batch
    launch(16'd3, 1'b0, 8'd2, 128'd9);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_start_o && (iter_o == 16'd1)) begin
        found = 1'b1;
        break;
      end
    end
    chk("ar_reached_run2", 128'(found), 128'd1);
    #2 n_reset = 1'b0;
    #1;
    chk("ar_busy",  128'(busy_o), 128'd0);
    chk("ar_start", 128'(core_start_o), 128'd0);
    chk("ar_trig",  128'(trigger_o), 128'd0);
    chk("ar_iter",  128'(iter_o), 128'd0);
    chk("ar_ct",    ct_o, 128'd0);
    chk("ar_pt",    core_pt_o, 128'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    launch(16'd1, 1'b0, 8'd0, 128'h55);
    wait_done(100, k);
    chk("ar_post_latency", 128'(k), 128'd5);
    chk("ar_post_iter",    128'(iter_o), 128'd1);
    chk("ar_post_ct",      ct_o, ONES ^ 128'h55);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
